// File: rtl/mem_stage.sv
`default_nettype none
// =============================================================================
// Module   : mem_stage
// Brief    : RISC-V MEM stage - data-memory load/store between EX and WB,
//            with a forwarding bundle exported to ID.
// Revision : 1.0
// =============================================================================
module mem_stage (
   input  logic         clk,
   input  logic         rst,
   input  logic [106:0] EX_to_MEM_data,
   input  logic         EX_to_MEM_valid,
   output logic         MEM_ready,
   output logic [69:0]  MEM_to_WB_data,
   output logic         MEM_to_WB_valid,
   input  logic         WB_ready,
   output logic [38:0]  MEM_to_ID_bypath_data,
   output logic [31:0]  Address,
   output logic         MemWrite,
   output logic [31:0]  Write_data,
   output logic [3:0]   Write_strb,
   output logic         MemRead,
   input  logic         Mem_Req_Ready,
   input  logic [31:0]  Read_data,
   input  logic         Read_data_Valid,
   output logic         Read_data_Ready
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_RESP = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [4:0]  waddr_q, waddr_d;
   logic        wen_q, wen_d;
   logic        is_load_q, is_load_d;
   logic        is_store_q, is_store_d;
   logic [2:0]  funct3_q, funct3_d;
   logic [31:0] alu_q, alu_d;
   logic [31:0] sdata_q, sdata_d;
   logic [31:0] wdata_q, wdata_d;

   logic [31:0] in_pc;
   logic [4:0]  in_waddr;
   logic        in_wen, in_mread, in_mwrite;
   logic [2:0]  in_funct3;
   logic [31:0] in_alu, in_sdata;
   logic        in_load, in_store;
   logic        accept;
   state_t      entry_state;

   assign {in_pc, in_waddr, in_wen, in_mread, in_mwrite, in_funct3, in_alu, in_sdata} = EX_to_MEM_data;

   // Both mem_read and mem_write set resolves to a store.
   assign in_store    = in_mwrite;
   assign in_load     = in_mread & ~in_mwrite;
   assign entry_state = (in_load || in_store) ? S_REQ : S_DONE;

   assign MEM_ready = (state_q == S_IDLE) || ((state_q == S_DONE) && WB_ready);
   assign accept    = EX_to_MEM_valid && MEM_ready;

   logic [1:0]  off;
   logic [7:0]  ld_byte;
   logic [15:0] ld_half;
   logic [31:0] ld_ext;

   assign off = alu_q[1:0];

   always_comb begin
      ld_byte = Read_data[{off, 3'b000} +: 8];
      ld_half = off[1] ? Read_data[31:16] : Read_data[15:0];
      case (funct3_q)
         3'b000:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
         3'b001:  ld_ext = {{16{ld_half[15]}}, ld_half};
         3'b100:  ld_ext = {24'd0, ld_byte};
         3'b101:  ld_ext = {16'd0, ld_half};
         default: ld_ext = Read_data;
      endcase
   end

   always_comb begin
      case (funct3_q[1:0])
         2'b00: begin
            Write_strb = 4'b0001 << off;
            Write_data = {4{sdata_q[7:0]}};
         end
         2'b01: begin
            Write_strb = 4'b0011 << {off[1], 1'b0};
            Write_data = {2{sdata_q[15:0]}};
         end
         default: begin
            Write_strb = 4'b1111;
            Write_data = sdata_q;
         end
      endcase
   end

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      waddr_d    = waddr_q;
      wen_d      = wen_q;
      is_load_d  = is_load_q;
      is_store_d = is_store_q;
      funct3_d   = funct3_q;
      alu_d      = alu_q;
      sdata_d    = sdata_q;
      wdata_d    = wdata_q;

      case (state_q)
         S_IDLE: if (accept) state_d = entry_state;
         S_REQ:  if (Mem_Req_Ready) state_d = is_load_q ? S_RESP : S_DONE;
         S_RESP: begin
            if (Read_data_Valid) begin
               state_d = S_DONE;
               wdata_d = ld_ext;
            end
         end
         S_DONE: if (WB_ready) state_d = accept ? entry_state : S_IDLE;
         default: state_d = S_IDLE;
      endcase

      if (accept) begin
         pc_d       = in_pc;
         waddr_d    = in_waddr;
         wen_d      = in_wen & ~in_store;
         is_load_d  = in_load;
         is_store_d = in_store;
         funct3_d   = in_funct3;
         alu_d      = in_alu;
         sdata_d    = in_sdata;
         wdata_d    = in_alu;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_IDLE;
         pc_q       <= 32'd0;
         waddr_q    <= 5'd0;
         wen_q      <= 1'b0;
         is_load_q  <= 1'b0;
         is_store_q <= 1'b0;
         funct3_q   <= 3'd0;
         alu_q      <= 32'd0;
         sdata_q    <= 32'd0;
         wdata_q    <= 32'd0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         waddr_q    <= waddr_d;
         wen_q      <= wen_d;
         is_load_q  <= is_load_d;
         is_store_q <= is_store_d;
         funct3_q   <= funct3_d;
         alu_q      <= alu_d;
         sdata_q    <= sdata_d;
         wdata_q    <= wdata_d;
      end
   end

   logic occupied;
   logic fwd_wen;
   logic fwd_pending;

   assign occupied    = (state_q != S_IDLE);
   assign fwd_wen     = occupied && wen_q && (waddr_q != 5'd0);
   // A load has no data to forward until its response lands in DONE.
   assign fwd_pending = occupied && is_load_q && (state_q != S_DONE);

   assign Address               = {alu_q[31:2], 2'b00};
   assign MemRead               = (state_q == S_REQ) && is_load_q;
   assign MemWrite              = (state_q == S_REQ) && is_store_q;
   assign Read_data_Ready       = (state_q == S_RESP);
   assign MEM_to_WB_valid       = (state_q == S_DONE);
   assign MEM_to_WB_data        = {pc_q, waddr_q, wen_q, wdata_q};
   assign MEM_to_ID_bypath_data = {fwd_wen, waddr_q, fwd_pending, wdata_q};

endmodule
`default_nettype wire

// File: tb/tb_mem_stage.sv
`default_nettype none
// =============================================================================
// Module   : tb_mem_stage
// Brief    : Directed and randomized self-checking bench for mem_stage.
// Revision : 1.0
// =============================================================================
module tb_mem_stage;

   logic         clk = 1'b0;
   logic         rst;
   logic [106:0] EX_to_MEM_data;
   logic         EX_to_MEM_valid;
   logic         MEM_ready;
   logic [69:0]  MEM_to_WB_data;
   logic         MEM_to_WB_valid;
   logic         WB_ready;
   logic [38:0]  MEM_to_ID_bypath_data;
   logic [31:0]  Address;
   logic         MemWrite;
   logic [31:0]  Write_data;
   logic [3:0]   Write_strb;
   logic         MemRead;
   logic         Mem_Req_Ready;
   logic [31:0]  Read_data;
   logic         Read_data_Valid;
   logic         Read_data_Ready;

   int total = 0;
   int bad   = 0;

   mem_stage dut (
      .clk                   (clk),
      .rst                   (rst),
      .EX_to_MEM_data        (EX_to_MEM_data),
      .EX_to_MEM_valid       (EX_to_MEM_valid),
      .MEM_ready             (MEM_ready),
      .MEM_to_WB_data        (MEM_to_WB_data),
      .MEM_to_WB_valid       (MEM_to_WB_valid),
      .WB_ready              (WB_ready),
      .MEM_to_ID_bypath_data (MEM_to_ID_bypath_data),
      .Address               (Address),
      .MemWrite              (MemWrite),
      .Write_data            (Write_data),
      .Write_strb            (Write_strb),
      .MemRead               (MemRead),
      .Mem_Req_Ready         (Mem_Req_Ready),
      .Read_data             (Read_data),
      .Read_data_Valid       (Read_data_Valid),
      .Read_data_Ready       (Read_data_Ready)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [69:0] obs, input logic [69:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic logic [106:0] pack(input logic [31:0] pc, input logic [4:0] wa, input logic wen,
                                         input logic mr, input logic mw, input logic [2:0] f3,
                                         input logic [31:0] alu, input logic [31:0] sd);
      return {pc, wa, wen, mr, mw, f3, alu, sd};
   endfunction

   function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] rd);
      longint unsigned off = 64'(addr) % 4;
      longint b = longint'((64'(rd) >> (8 * off)) % 256);
      longint h = longint'((64'(rd) >> (16 * (off / 2))) % 65536);
      case (f3)
         3'd0:    return 32'((b >= 128) ? b - 256 : b);
         3'd1:    return 32'((h >= 32768) ? h - 65536 : h);
         3'd4:    return 32'(b);
         3'd5:    return 32'(h);
         default: return rd;
      endcase
   endfunction

   function automatic logic [3:0] ref_strb(input logic [2:0] f3, input logic [31:0] addr);
      int off = int'(addr % 4);
      if (f3 == 3'd0) return 4'(1 << off);
      if (f3 == 3'd1) return (off >= 2) ? 4'hC : 4'h3;
      return 4'hF;
   endfunction

   function automatic logic [31:0] ref_wdata(input logic [2:0] f3, input logic [31:0] sd);
      if (f3 == 3'd0) return (sd % 256) * 32'h0101_0101;
      if (f3 == 3'd1) return (sd % 65536) * 32'h0001_0001;
      return sd;
   endfunction

   // Runs one instruction through the stage; starts and ends 1 time unit after a rising edge.
   task automatic run_op(input logic [31:0] pc, input logic [4:0] wa, input logic wen,
                         input logic mr, input logic mw, input logic [2:0] f3,
                         input logic [31:0] alu, input logic [31:0] sd, input logic [31:0] rd,
                         input int req_dly, input int rsp_dly, input int hold);
      logic        is_st, is_ld, e_wen;
      logic [31:0] e_wd;
      is_st = mw;
      is_ld = mr && !mw;
      e_wen = wen && !is_st;
      e_wd  = is_ld ? ref_load(f3, alu, rd) : alu;

      EX_to_MEM_data  = pack(pc, wa, wen, mr, mw, f3, alu, sd);
      EX_to_MEM_valid = 1'b1;
      WB_ready        = 1'b1;
      @(negedge clk);
      chk("ready_idle", MEM_ready, 1);
      @(posedge clk); #1;
      EX_to_MEM_valid = 1'b0;

      if (is_st || is_ld) begin
         for (int i = 0; i <= req_dly; i++) begin
            Mem_Req_Ready   = (i == req_dly);
            Read_data_Valid = 1'b1;
            Read_data       = ~rd;
            @(negedge clk);
            chk("memread", MemRead, is_ld);
            chk("memwrite", MemWrite, is_st);
            chk("address", Address, alu & 32'hFFFF_FFFC);
            if (is_st) begin
               chk("strb", Write_strb, ref_strb(f3, alu));
               chk("wdata", Write_data, ref_wdata(f3, sd));
            end
            chk("rdready_req", Read_data_Ready, 0);
            chk("pending_req", MEM_to_ID_bypath_data[32], is_ld);
            chk("fwdwen_req", MEM_to_ID_bypath_data[38], e_wen && (wa != 5'd0));
            chk("valid_req", MEM_to_WB_valid, 0);
            chk("ready_busy", MEM_ready, 0);
            @(posedge clk); #1;
         end
         Mem_Req_Ready   = 1'b0;
         Read_data_Valid = 1'b0;
         if (is_ld) begin
            for (int j = 0; j <= rsp_dly; j++) begin
               Read_data_Valid = (j == rsp_dly);
               Read_data       = (j == rsp_dly) ? rd : $urandom;
               @(negedge clk);
               chk("rdready_resp", Read_data_Ready, 1);
               chk("memread_resp", MemRead, 0);
               chk("pending_resp", MEM_to_ID_bypath_data[32], 1);
               chk("valid_resp", MEM_to_WB_valid, 0);
               @(posedge clk); #1;
            end
            Read_data_Valid = 1'b0;
            Read_data       = $urandom;
         end
      end

      for (int k = 0; k <= hold; k++) begin
         WB_ready = (k == hold);
         @(negedge clk);
         chk("valid_done", MEM_to_WB_valid, 1);
         chk("wb_bundle", MEM_to_WB_data, {pc, wa, e_wen, e_wd});
         chk("bypath_done", MEM_to_ID_bypath_data, {e_wen && (wa != 5'd0), wa, 1'b0, e_wd});
         chk("ready_done", MEM_ready, (k == hold));
         chk("req_done", {MemRead, MemWrite, Read_data_Ready}, 0);
         @(posedge clk); #1;
      end
      WB_ready = 1'b1;
      @(negedge clk);
      chk("valid_after", MEM_to_WB_valid, 0);
      chk("ready_after", MEM_ready, 1);
      @(posedge clk); #1;
   endtask

   initial begin
      logic [106:0] d1, d2, d3;
      rst             = 1'b1;
      EX_to_MEM_data  = '0;
      EX_to_MEM_valid = 1'b0;
      WB_ready        = 1'b1;
      Mem_Req_Ready   = 1'b0;
      Read_data       = 32'd0;
      Read_data_Valid = 1'b0;
      #2;
      chk("rst_ready", MEM_ready, 1);
      chk("rst_valid", MEM_to_WB_valid, 0);
      chk("rst_req", {MemRead, MemWrite, Read_data_Ready}, 0);
      chk("rst_bypath", MEM_to_ID_bypath_data, 0);
      chk("rst_wb", MEM_to_WB_data, 0);
      @(negedge clk); @(negedge clk);
      rst = 1'b0;
      @(posedge clk); #1;

      // ALU op with single-cycle latency
      run_op(32'h100, 5'd5, 1'b1, 1'b0, 1'b0, 3'd0, 32'h1234, 32'h0, 32'h0, 0, 0, 0);

      // Three back-to-back ALU ops
      d1 = pack(32'h10, 5'd1, 1'b1, 1'b0, 1'b0, 3'd0, 32'h11, 32'h0);
      d2 = pack(32'h14, 5'd2, 1'b1, 1'b0, 1'b0, 3'd0, 32'h22, 32'h0);
      d3 = pack(32'h18, 5'd3, 1'b0, 1'b0, 1'b0, 3'd0, 32'h33, 32'h0);
      EX_to_MEM_data = d1; EX_to_MEM_valid = 1'b1;
      @(posedge clk); #1;
      EX_to_MEM_data = d2;
      @(negedge clk);
      chk("b2b_1", {MEM_to_WB_valid, MEM_ready, MEM_to_WB_data}, {2'b11, 32'h10, 5'd1, 1'b1, 32'h11});
      @(posedge clk); #1;
      EX_to_MEM_data = d3;
      @(negedge clk);
      chk("b2b_2", {MEM_to_WB_valid, MEM_ready, MEM_to_WB_data}, {2'b11, 32'h14, 5'd2, 1'b1, 32'h22});
      @(posedge clk); #1;
      EX_to_MEM_valid = 1'b0;
      @(negedge clk);
      chk("b2b_3", {MEM_to_WB_valid, MEM_to_WB_data}, {1'b1, 32'h18, 5'd3, 1'b0, 32'h33});
      @(posedge clk); #1;
      @(negedge clk);
      chk("b2b_idle", MEM_to_WB_valid, 0);
      @(posedge clk); #1;

      // Loads
      run_op(32'h200, 5'd6, 1'b1, 1'b1, 1'b0, 3'd0, 32'h2003, 32'h0, 32'h80FF_FF00, 2, 3, 0);
      run_op(32'h204, 5'd7, 1'b1, 1'b1, 1'b0, 3'd5, 32'h3002, 32'h0, 32'hBEEF_1234, 0, 0, 0);
      run_op(32'h208, 5'd8, 1'b1, 1'b1, 1'b0, 3'd2, 32'h3000, 32'h0, 32'hBEEF_1234, 1, 1, 1);

      // Stores
      run_op(32'h300, 5'd9, 1'b1, 1'b0, 1'b1, 3'd0, 32'h4001, 32'hAB, 32'h0, 0, 0, 0);
      run_op(32'h304, 5'd10, 1'b1, 1'b0, 1'b1, 3'd1, 32'h4002, 32'hCDEF, 32'h0, 1, 0, 0);

      // WB stall with a waiting instruction, then same-cycle accept on release
      EX_to_MEM_data = pack(32'h400, 5'd11, 1'b1, 1'b0, 1'b0, 3'd0, 32'hA5A5, 32'h0);
      EX_to_MEM_valid = 1'b1;
      @(posedge clk); #1;
      EX_to_MEM_data = pack(32'h404, 5'd12, 1'b1, 1'b0, 1'b0, 3'd0, 32'h5A5A, 32'h0);
      WB_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("stall_bundle", {MEM_to_WB_valid, MEM_ready, MEM_to_WB_data}, {2'b10, 32'h400, 5'd11, 1'b1, 32'hA5A5});
         @(posedge clk); #1;
      end
      WB_ready = 1'b1;
      @(negedge clk);
      chk("stall_release", {MEM_ready, MEM_to_WB_data}, {1'b1, 32'h400, 5'd11, 1'b1, 32'hA5A5});
      @(posedge clk); #1;
      EX_to_MEM_valid = 1'b0;
      @(negedge clk);
      chk("stall_next", {MEM_to_WB_valid, MEM_to_WB_data}, {1'b1, 32'h404, 5'd12, 1'b1, 32'h5A5A});
      @(posedge clk); #1;

      // Randomized instruction mix
      for (int n = 0; n < 40; n++) begin
         int          kind;
         logic [2:0]  f3;
         kind = int'($urandom_range(0, 3));
         f3   = (kind == 1) ? 3'($urandom_range(0, 7)) : 3'($urandom_range(0, 2));
         run_op($urandom, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
                (kind == 1) || (kind == 3), (kind >= 2), f3, $urandom, $urandom, $urandom,
                int'($urandom_range(0, 2)), int'($urandom_range(0, 2)), int'($urandom_range(0, 2)));
      end

      // Reset while a load is requesting
      EX_to_MEM_data = pack(32'h500, 5'd13, 1'b1, 1'b1, 1'b0, 3'd2, 32'h6000, 32'h0);
      EX_to_MEM_valid = 1'b1;
      @(posedge clk); #1;
      EX_to_MEM_valid = 1'b0;
      @(negedge clk);
      chk("pre_rst_req", MemRead, 1);
      #2 rst = 1'b1;
      #1;
      chk("rst_req_drop", {MemRead, MemWrite, Read_data_Ready, MEM_to_WB_valid, MEM_ready}, 5'b00001);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk); #1;

      // Reset while waiting in RESP
      EX_to_MEM_data = pack(32'h600, 5'd14, 1'b1, 1'b1, 1'b0, 3'd0, 32'h7001, 32'h0);
      EX_to_MEM_valid = 1'b1;
      @(posedge clk); #1;
      EX_to_MEM_valid = 1'b0;
      Mem_Req_Ready   = 1'b1;
      @(posedge clk); #1;
      Mem_Req_Ready   = 1'b0;
      @(negedge clk);
      chk("pre_rst_resp", Read_data_Ready, 1);
      #2 rst = 1'b1;
      #1;
      chk("rst_resp_drop", {MemRead, Read_data_Ready, MEM_to_WB_valid, MEM_ready}, 4'b0001);
      chk("rst_resp_bypath", MEM_to_ID_bypath_data, 0);
      @(posedge clk); #1;
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk); #1;
      @(negedge clk);
      chk("post_rst_idle", {MEM_to_WB_valid, MEM_ready, Read_data_Ready}, 3'b010);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
